// File: rtl/fpu_pkg.sv
// Shared FPU constants: custom float field layout, bias, status bit indices
// and the float-to-int conversion state encoding.
package fpu_pkg;
    localparam int BIAS     = 31;
    localparam int EXP_W    = 6;
    localparam int MANT_W   = 25;
    localparam int SIG_W    = MANT_W + 1;
    localparam int E_W      = EXP_W + 1;

    localparam int SIGN_POS = 31;
    localparam int EXP_HI   = 30;
    localparam int EXP_LO   = 25;
    localparam int MANT_HI  = 24;
    localparam int MANT_LO  = 0;

    localparam int ST_OVF   = 3;
    localparam int ST_INX   = 2;
    localparam int ST_NEG   = 1;
    localparam int ST_ZERO  = 0;

    typedef enum logic [2:0] {
        F2I_IDLE,
        F2I_UNPACK,
        F2I_SHIFT,
        F2I_PACK,
        F2I_DONE
    } f2i_state_t;
endpackage

// File: rtl/fp_unpack.sv
// Splits a packed custom float into sign, unbiased exponent and significand
// with the hidden one restored. Purely combinational.
module fp_unpack
    import fpu_pkg::*;
#(
    parameter int BIAS = 31
) (
    input  logic              [31:0] op,
    output logic                     sign,
    output logic signed        [6:0] e,
    output logic              [25:0] sig,
    output logic                     is_zero
);
    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] mant_f;

    assign sign    = op[SIGN_POS];
    assign exp_f   = op[EXP_HI:EXP_LO];
    assign mant_f  = op[MANT_HI:MANT_LO];
    // 7-bit modular subtraction yields the correct two's-complement e (-31..32).
    assign e       = signed'(7'({1'b0, exp_f}) - 7'(BIAS));
    assign sig     = {1'b1, mant_f};
    assign is_zero = (exp_f == '0) && (mant_f == '0);
endmodule

// File: rtl/fp_to_int.sv
// Custom float -> signed 32-bit integer, truncating toward zero, saturating.
// Iterative shifter, one bit per cycle; result held in DONE until consumed.
module fp_to_int
    import fpu_pkg::*;
#(
    parameter int BIAS  = 31,
    parameter int ACC_W = 58
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);
    f2i_state_t         state_q, state_d;
    logic [31:0]        op_q, op_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               sticky_q, sticky_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        data_d;
    logic [3:0]         status_d;
    logic               valid_d;
    logic [31:0]        res;

    logic               u_sign;
    logic signed [6:0]  u_e;
    logic [25:0]        u_sig;
    logic               u_zero;

    fp_unpack #(.BIAS(BIAS)) u_unpack (
        .op      (op_q),
        .sign    (u_sign),
        .e       (u_e),
        .sig     (u_sig),
        .is_zero (u_zero)
    );

    assign in_ready = (state_q == F2I_IDLE);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        left_d   = left_q;
        sticky_d = sticky_q;
        ovf_d    = ovf_q;
        data_d   = data_out;
        status_d = status_out;
        valid_d  = out_valid;
        res      = u_sign ? (32'd0 - acc_q[31:0]) : acc_q[31:0];

        case (state_q)
            F2I_IDLE: begin
                if (in_valid) begin
                    op_d    = op_in;
                    state_d = F2I_UNPACK;
                end
            end
            F2I_UNPACK: begin
                acc_d    = '0;
                cnt_d    = '0;
                left_d   = 1'b0;
                sticky_d = 1'b0;
                ovf_d    = 1'b0;
                state_d  = F2I_PACK;
                if (u_zero) begin
                    acc_d = '0;
                end else if (u_e < 7'sd0) begin
                    sticky_d = 1'b1;
                end else if (u_e >= 7'sd31) begin
                    // Negation in PACK leaves 0x80000000 unchanged, so both
                    // saturation values can be loaded as-is.
                    acc_d[31:0] = u_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
                    ovf_d       = !(u_sign && (u_e == 7'sd31) && (u_sig[24:0] == '0));
                end else begin
                    acc_d   = ACC_W'(u_sig);
                    state_d = F2I_SHIFT;
                    if (u_e <= 7'sd24) begin
                        cnt_d  = 5'(7'sd25 - u_e);
                        left_d = 1'b0;
                    end else begin
                        cnt_d  = 5'(u_e - 7'sd25);
                        left_d = 1'b1;
                    end
                end
            end
            F2I_SHIFT: begin
                if (cnt_q == '0) begin
                    state_d = F2I_PACK;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                    if (left_q) begin
                        acc_d = acc_q << 1;
                    end else begin
                        acc_d    = acc_q >> 1;
                        sticky_d = sticky_q | acc_q[0];
                    end
                end
            end
            F2I_PACK: begin
                data_d           = res;
                status_d[ST_OVF]  = ovf_q;
                status_d[ST_INX]  = sticky_q;
                status_d[ST_NEG]  = res[31];
                status_d[ST_ZERO] = (res == 32'd0);
                valid_d          = 1'b1;
                state_d          = F2I_DONE;
            end
            F2I_DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = F2I_IDLE;
                end
            end
            default: state_d = F2I_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= F2I_IDLE;
            op_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            sticky_q   <= 1'b0;
            ovf_q      <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
            out_valid  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            left_q     <= left_d;
            sticky_q   <= sticky_d;
            ovf_q      <= ovf_d;
            data_out   <= data_d;
            status_out <= status_d;
            out_valid  <= valid_d;
        end
    end
endmodule
